pwm_deadtime_gate_stage: RTL and testbench

Downstream gate-drive stage for the quad PWM FET driver. Takes the four raw PWM bits from the PWM generator, one per half-bridge, and produces complementary high-side/low-side gate enables. A programmable dead band is inserted on every transition so both FETs of a leg are never on together. An external active-low fault pin, synchronised and latched, forces every gate off until software clears it. The outputs feed the IO pad buffers (buf_io_out) inside the wrapped design.

---
 rtl/pwm_drv_pkg.sv | 16 +
 rtl/deadtime_channel.sv | 89 ++++++++
 rtl/pwm_deadtime_gate_stage.sv | 67 ++++++
 tb/tb_pwm_deadtime_gate_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_drv_pkg.sv
// Shared types and default sizing for the quad PWM gate-drive stage.
// Channel state encoding is common to every dead-band channel instance.
package pwm_drv_pkg;

    localparam int NCH_DEF  = 4;
    localparam int DT_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        DT_RISE,
        HS_ON,
        DT_FALL,
        LS_ON
    } chan_state_t;

endpackage

// File: rtl/deadtime_channel.sv
// One half-bridge leg: turns a raw PWM bit into complementary gate enables
// with a programmable dead band between every change of conducting side.
module deadtime_channel
    import pwm_drv_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            pwm,
    input  logic [DT_W-1:0] dead_time,
    output logic            hs,
    output logic            ls
);

    chan_state_t     state;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] load;

    // A zero dead time still leaves one full cycle with both gates off.
    assign load = (dead_time == '0) ? '0 : dead_time - DT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hs    <= 1'b0;
            ls    <= 1'b0;
        end else if (kill) begin
            state <= IDLE;
            cnt   <= '0;
            hs    <= 1'b0;
            ls    <= 1'b0;
        end else begin
            hs <= 1'b0;
            ls <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= load;
                    state <= pwm ? DT_RISE : DT_FALL;
                end
                DT_RISE: begin
                    if (!pwm) begin
                        state <= DT_FALL;
                        cnt   <= load;
                    end else if (cnt == '0) begin
                        state <= HS_ON;
                        hs    <= 1'b1;
                    end else begin
                        cnt <= cnt - DT_W'(1);
                    end
                end
                HS_ON: begin
                    if (!pwm) begin
                        state <= DT_FALL;
                        cnt   <= load;
                    end else begin
                        hs <= 1'b1;
                    end
                end
                DT_FALL: begin
                    if (pwm) begin
                        state <= DT_RISE;
                        cnt   <= load;
                    end else if (cnt == '0) begin
                        state <= LS_ON;
                        ls    <= 1'b1;
                    end else begin
                        cnt <= cnt - DT_W'(1);
                    end
                end
                LS_ON: begin
                    if (pwm) begin
                        state <= DT_RISE;
                        cnt   <= load;
                    end else begin
                        ls <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_deadtime_gate_stage.sv
// Gate-drive stage: fault pin synchroniser, latched fault flag and the
// shared kill that forces every dead-band channel back to IDLE.
module pwm_deadtime_gate_stage
    import pwm_drv_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int DT_W = DT_W_DEF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            enable,
    input  logic [NCH-1:0]  pwm_i,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault_n_i,
    input  logic            fault_clear,
    output logic [NCH-1:0]  hs_o,
    output logic [NCH-1:0]  ls_o,
    output logic            fault_o
);

    logic fault_meta;
    logic fault_sync;
    logic fault_set;
    logic kill;

    // Flops reset high so a released reset never looks like a fault.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            fault_meta <= 1'b1;
            fault_sync <= 1'b1;
        end else begin
            fault_meta <= fault_n_i;
            fault_sync <= fault_meta;
        end
    end

    assign fault_set = !fault_sync;

    // Set has priority, so a clear while the pin is still low is dropped.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            fault_o <= 1'b0;
        end else if (fault_set) begin
            fault_o <= 1'b1;
        end else if (fault_clear) begin
            fault_o <= 1'b0;
        end
    end

    // Including fault_set lets the gates drop on the same edge the latch sets.
    assign kill = !enable || fault_o || fault_set;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        deadtime_channel #(
            .DT_W (DT_W)
        ) u_chan (
            .clk       (wb_clk_i),
            .rst_n     (wb_rst_n),
            .kill      (kill),
            .pwm       (pwm_i[i]),
            .dead_time (dead_time),
            .hs        (hs_o[i]),
            .ls        (ls_o[i])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime_gate_stage.sv
// Scoreboard bench for the gate-drive stage: a run-length reference model
// predicts each edge's outputs, a separate monitor compares them.
module tb_pwm_deadtime_gate_stage;

    localparam int NCH  = 4;
    localparam int DT_W = 8;

    logic            clk;
    logic            rst_n;
    logic            enable;
    logic [NCH-1:0]  pwm_i;
    logic [DT_W-1:0] dead_time;
    logic            fault_n_i;
    logic            fault_clear;
    logic [NCH-1:0]  hs_o;
    logic [NCH-1:0]  ls_o;
    logic            fault_o;

    pwm_deadtime_gate_stage #(
        .NCH  (NCH),
        .DT_W (DT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .enable      (enable),
        .pwm_i       (pwm_i),
        .dead_time   (dead_time),
        .fault_n_i   (fault_n_i),
        .fault_clear (fault_clear),
        .hs_o        (hs_o),
        .ls_o        (ls_o),
        .fault_o     (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0] hs;
        logic [NCH-1:0] ls;
        logic           flt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a gate is on once pwm has held its level for D edges
    // since the last change, or since the channel was last released from kill.
    int edge_no;
    int run_start[NCH];
    int run_len[NCH];
    bit was_killed[NCH];
    bit last_pwm[NCH];
    bit m_fault;
    bit fn_d1;
    bit fn_d2;

    function automatic void reset_model();
        edge_no = 0;
        m_fault = 1'b0;
        fn_d1   = 1'b1;
        fn_d2   = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            run_start[c]  = 0;
            run_len[c]    = 1;
            was_killed[c] = 1'b1;
            last_pwm[c]   = 1'b0;
        end
    endfunction

    function automatic void check_value(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endfunction

    task automatic apply_stimulus(input bit en, input logic [NCH-1:0] pwm,
                                  input int dt, input bit fn, input bit clr);
        exp_t e;
        bit   fault_seen;
        bit   kill;
        enable      = en;
        pwm_i       = pwm;
        dead_time   = DT_W'(dt);
        fault_n_i   = fn;
        fault_clear = clr;
        fault_seen = (fn_d2 == 1'b0);
        kill       = !en || m_fault || fault_seen;
        if (fault_seen) m_fault = 1'b1;
        else if (clr)   m_fault = 1'b0;
        fn_d2 = fn_d1;
        fn_d1 = fn;
        e.hs  = '0;
        e.ls  = '0;
        e.flt = m_fault;
        for (int c = 0; c < NCH; c++) begin
            if (kill) begin
                was_killed[c] = 1'b1;
            end else begin
                if (was_killed[c] || (pwm[c] != last_pwm[c])) begin
                    run_start[c] = edge_no;
                    run_len[c]   = (dt < 1) ? 1 : dt;
                end
                was_killed[c] = 1'b0;
                if (edge_no - run_start[c] >= run_len[c]) begin
                    e.hs[c] = pwm[c];
                    e.ls[c] = !pwm[c];
                end
            end
            last_pwm[c] = pwm[c];
        end
        exp_q.push_back(e);
        edge_no++;
        @(negedge clk);
    endtask

    task automatic check_output(input exp_t e);
        check_value("hs_o", 32'(hs_o), 32'(e.hs));
        check_value("ls_o", 32'(ls_o), 32'(e.ls));
        check_value("fault_o", 32'(fault_o), 32'(e.flt));
        check_value("overlap", 32'(hs_o & ls_o), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            #2;
            budget--;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : stimulus
        bit [NCH-1:0] rp;
        int           rdt;
        bit           rfn;
        rst_n       = 1'b0;
        enable      = 1'b0;
        pwm_i       = '0;
        dead_time   = '0;
        fault_n_i   = 1'b1;
        fault_clear = 1'b0;
        reset_model();
        repeat (3) @(posedge clk);
        #2;
        check_value("reset_hs", 32'(hs_o), 32'd0);
        check_value("reset_ls", 32'(ls_o), 32'd0);
        check_value("reset_fault", 32'(fault_o), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;

        // Settle LS_ON, then raise channel 0 only with dead_time 3.
        repeat (6) apply_stimulus(1, 4'b0000, 3, 1, 0);
        repeat (8) apply_stimulus(1, 4'b0001, 3, 1, 0);

        // dead_time 0 behaves as a single-cycle gap.
        for (int i = 0; i < 24; i++)
            apply_stimulus(1, ((i / 4) % 2 == 1) ? 4'b1111 : 4'b0000, 0, 1, 0);

        // Short high pulse must never reach the high side.
        repeat (10) apply_stimulus(1, 4'b0000, 5, 1, 0);
        repeat (2)  apply_stimulus(1, 4'b0101, 5, 1, 0);
        repeat (10) apply_stimulus(1, 4'b0000, 5, 1, 0);

        // Fault while conducting, ignored clear, then real clear and recovery.
        repeat (8) apply_stimulus(1, 4'b1111, 2, 1, 0);
        repeat (3) apply_stimulus(1, 4'b1111, 2, 0, 0);
        apply_stimulus(1, 4'b1111, 2, 0, 1);
        repeat (2) apply_stimulus(1, 4'b1111, 2, 0, 0);
        repeat (3) apply_stimulus(1, 4'b1111, 2, 1, 0);
        apply_stimulus(1, 4'b1111, 2, 1, 1);
        repeat (6) apply_stimulus(1, 4'b1111, 2, 1, 0);

        // Enable drop during the rising dead band.
        repeat (8) apply_stimulus(1, 4'b0000, 4, 1, 0);
        repeat (2) apply_stimulus(1, 4'b1111, 4, 1, 0);
        repeat (2) apply_stimulus(0, 4'b1111, 4, 1, 0);
        repeat (8) apply_stimulus(1, 4'b1111, 4, 1, 0);

        rp  = '0;
        rdt = 3;
        rfn = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 5) == 0) rp[c] = ~rp[c];
            if ($urandom_range(0, 49) == 0) rdt = $urandom_range(0, 6);
            if (rfn) rfn = ($urandom_range(0, 399) != 0);
            else     rfn = ($urandom_range(0, 7) == 0);
            apply_stimulus($urandom_range(0, 299) != 0, rp, rdt,
                           rfn, $urandom_range(0, 19) == 0);
        end

        // Bring gates on, then drop reset between edges.
        repeat (4)  apply_stimulus(1, 4'b1111, 2, 1, 1);
        repeat (10) apply_stimulus(1, 4'b1111, 2, 1, 0);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_hs", 32'(hs_o), 32'd0);
        check_value("async_reset_ls", 32'(ls_o), 32'd0);
        check_value("async_reset_fault", 32'(fault_o), 32'd0);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) apply_stimulus(1, 4'b1010, 2, 1, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
